// File: rtl/sram22_generic.sv
// Generic single-port SRAM with per-lane write mask, power-up zero-fill and 1/2-cycle read latency.
// Optional per-lane even-parity storage and checking is enabled by defining SRAM22_PARITY_EN.
module sram22_generic #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
`ifdef SRAM22_PARITY_EN
    input  logic                   perr_inject,
    output logic                   parity_err,
`endif
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   init_busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LW        = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];
    logic                    rd_req_s;
    logic                    wr_req_s;
    logic                    rsp_vld_s;
    logic [DATA_WIDTH-1:0]   rsp_data_s;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dout_valid_q;

`ifdef SRAM22_PARITY_EN
    logic [WMASK_WIDTH-1:0]  par_q [RAM_DEPTH];
    logic                    rd_err_s;
    logic                    rsp_err_s;
    logic                    parity_err_q;

    function automatic logic [WMASK_WIDTH-1:0] lane_parity(input logic [DATA_WIDTH-1:0] word);
        logic [WMASK_WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < WMASK_WIDTH; k++) begin
            p[k] = ^word[k*LW +: LW];
        end
        return p;
    endfunction
`endif

    // Requests are only honoured once the zero-fill has finished.
    assign rd_req_s = (state_q == ST_READY) && en && !we;
    assign wr_req_s = (state_q == ST_READY) && en && we;

    // Init/ready sequencing: walk cnt over every word, then stay ready until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and fill counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array: zero-fill during init, masked lane writes when ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_req_s) begin
                for (int k = 0; k < WMASK_WIDTH; k++) begin
                    if (wmask[k]) begin
                        mem_q[addr][k*LW +: LW] <= din[k*LW +: LW];
                    end
                end
            end
        end
    end

`ifdef SRAM22_PARITY_EN
    // Parity array: zero words have even parity 0; injection flips the written lanes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                par_q[cnt_q] <= '0;
            end else if (wr_req_s) begin
                for (int k = 0; k < WMASK_WIDTH; k++) begin
                    if (wmask[k]) begin
                        par_q[addr][k] <= (^din[k*LW +: LW]) ^ perr_inject;
                    end
                end
            end
        end
    end

    assign rd_err_s = |(lane_parity(mem_q[addr]) ^ par_q[addr]);
`endif

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_vld_q;
            logic [DATA_WIDTH-1:0] s1_data_q;
`ifdef SRAM22_PARITY_EN
            logic                  s1_err_q;
`endif
            // Extra pipeline stage between the array read and dout.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
`ifdef SRAM22_PARITY_EN
                    s1_err_q  <= 1'b0;
`endif
                end else begin
                    s1_vld_q <= rd_req_s;
                    if (rd_req_s) begin
                        s1_data_q <= mem_q[addr];
`ifdef SRAM22_PARITY_EN
                        s1_err_q  <= rd_err_s;
`endif
                    end
                end
            end
            assign rsp_vld_s  = s1_vld_q;
            assign rsp_data_s = s1_data_q;
`ifdef SRAM22_PARITY_EN
            assign rsp_err_s  = s1_err_q;
`endif
        end else begin : g_lat1
            assign rsp_vld_s  = rd_req_s;
            assign rsp_data_s = mem_q[addr];
`ifdef SRAM22_PARITY_EN
            assign rsp_err_s  = rd_err_s;
`endif
        end
    endgenerate

    // Output register: dout only moves when a read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rsp_vld_s;
            if (rsp_vld_s) begin
                dout_q <= rsp_data_s;
            end
        end
    end

`ifdef SRAM22_PARITY_EN
    // Parity error flag pulses alongside dout_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rsp_vld_s && rsp_err_s;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign init_busy  = (state_q == ST_INIT);

endmodule
